// File: rtl/alu_muldiv_seq_if.sv
// ============================================================================
// Module      : alu_muldiv_seq_if
// Description : Request/response and shared-ALU bundle for the mul/div sequencer
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface alu_muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            alu_own;
    logic [XLEN-1:0] alu_srca;
    logic [XLEN-1:0] alu_srcb;
    logic [2:0]      alu_control;
    logic [XLEN-1:0] alu_result;

    // Sequencer side
    modport slave (
        input  start, op, a, b, flush, alu_result,
        output busy, done, result, alu_own, alu_srca, alu_srcb, alu_control
    );

    // Pipeline / EX-stage side
    modport master (
        output start, op, a, b, flush, alu_result,
        input  busy, done, result, alu_own, alu_srca, alu_srcb, alu_control
    );
endinterface

`default_nettype wire

// File: rtl/alu_muldiv_seq.sv
// ============================================================================
// Module      : alu_muldiv_seq
// Description : Iterative MUL/DIVU/REMU sequencer borrowing the EX-stage ALU
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset,
    alu_muldiv_seq_if.slave   bus
);

    localparam int unsigned   c_CNT_W    = $clog2(XLEN);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(XLEN - 1);
    localparam logic [1:0]    c_OP_MUL   = 2'b00;
    localparam logic [1:0]    c_OP_DIVU  = 2'b01;
    localparam logic [1:0]    c_OP_REMU  = 2'b10;
    localparam logic [2:0]    c_ALU_ADD  = 3'b000;
    localparam logic [2:0]    c_ALU_SUB  = 3'b001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [1:0]           r_op, w_op_nxt;
    // r_acc: product accumulator (MUL) or partial remainder (DIV)
    // r_opa: multiplier (MUL) or dividend shifting into quotient (DIV)
    // r_opb: multiplicand (MUL) or divisor (DIV)
    logic [XLEN-1:0]      r_acc, w_acc_nxt;
    logic [XLEN-1:0]      r_opa, w_opa_nxt;
    logic [XLEN-1:0]      r_opb, w_opb_nxt;
    logic [XLEN-1:0]      r_result, w_result_nxt;

    logic [XLEN-1:0]      w_shifted;
    logic                 w_carry;
    logic                 w_ge;
    logic [XLEN-1:0]      w_srca;
    logic [XLEN-1:0]      w_srcb;
    logic [2:0]           w_control;

    // Restoring-division trial: a carried-out bit guarantees shifted >= divisor
    assign w_shifted = {r_acc[XLEN-2:0], r_opa[XLEN-1]};
    assign w_carry   = r_acc[XLEN-1];
    assign w_ge      = w_carry || (w_shifted >= r_opb);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_acc    <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_op     <= w_op_nxt;
            r_acc    <= w_acc_nxt;
            r_opa    <= w_opa_nxt;
            r_opb    <= w_opb_nxt;
            r_result <= w_result_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_op_nxt     = r_op;
        w_acc_nxt    = r_acc;
        w_opa_nxt    = r_opa;
        w_opb_nxt    = r_opb;
        w_result_nxt = r_result;
        w_srca       = '0;
        w_srcb       = '0;
        w_control    = c_ALU_ADD;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (r_state == S_DONE) begin
                    w_state_nxt = S_IDLE;
                end
                if (bus.start && !bus.flush) begin
                    w_op_nxt  = bus.op;
                    w_cnt_nxt = '0;
                    w_acc_nxt = '0;
                    case (bus.op)
                        c_OP_MUL: begin
                            w_state_nxt = S_RUN;
                            w_opa_nxt   = bus.b;
                            w_opb_nxt   = bus.a;
                        end
                        c_OP_DIVU, c_OP_REMU: begin
                            w_opa_nxt = bus.a;
                            w_opb_nxt = bus.b;
                            if (bus.b == '0) begin
                                // Divide by zero resolves without touching the ALU
                                w_state_nxt  = S_DONE;
                                w_result_nxt = (bus.op == c_OP_DIVU) ? '1 : bus.a;
                            end else begin
                                w_state_nxt = S_RUN;
                            end
                        end
                        default: begin
                            w_state_nxt  = S_DONE;
                            w_result_nxt = '0;
                        end
                    endcase
                end
            end

            S_RUN: begin
                w_srcb = r_opb;
                if (r_op == c_OP_MUL) begin
                    w_srca    = r_acc;
                    w_control = c_ALU_ADD;
                    w_acc_nxt = r_opa[0] ? bus.alu_result : r_acc;
                    w_opb_nxt = r_opb << 1;
                    w_opa_nxt = r_opa >> 1;
                end else begin
                    w_srca    = w_shifted;
                    w_control = c_ALU_SUB;
                    w_acc_nxt = w_ge ? bus.alu_result : w_shifted;
                    w_opa_nxt = {r_opa[XLEN-2:0], w_ge};
                end
                w_cnt_nxt = r_cnt + c_CNT_W'(1);

                if (bus.flush) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == c_LAST) begin
                    w_state_nxt  = S_DONE;
                    w_result_nxt = (r_op == c_OP_DIVU) ? w_opa_nxt : w_acc_nxt;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.busy        = (r_state == S_RUN);
    assign bus.done        = (r_state == S_DONE);
    assign bus.result      = r_result;
    assign bus.alu_own     = (r_state == S_RUN);
    assign bus.alu_srca    = w_srca;
    assign bus.alu_srcb    = w_srcb;
    assign bus.alu_control = w_control;

endmodule

`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
// ============================================================================
// Module      : tb_alu_muldiv_seq
// Description : Directed + random bench for alu_muldiv_seq with a shared-ALU model
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_muldiv_seq;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic reset;
    int   n_assert = 0;
    int   n_fail   = 0;
    logic [31:0] last_result;

    alu_muldiv_seq_if #(.XLEN(XLEN)) bif ();

    alu_muldiv_seq #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    // Shared EX-stage ALU: combinational add/sub
    assign bif.alu_result = (bif.alu_control == 3'b001) ? (bif.alu_srca - bif.alu_srcb)
                                                        : (bif.alu_srca + bif.alu_srcb);

    function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] p;
        case (op)
            2'b00: begin
                p = 64'(a) * 64'(b);
                return p[31:0];
            end
            2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b10:   return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"},  32'(bif.busy),        32'd0);
        check({tag, "_own"},   32'(bif.alu_own),     32'd0);
        check({tag, "_srca"},  bif.alu_srca,         32'd0);
        check({tag, "_srcb"},  bif.alu_srcb,         32'd0);
        check({tag, "_ctl"},   32'(bif.alu_control), 32'd0);
    endtask

    // Issues one operation at the current negedge, returns at the negedge where done is seen
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
        int          lat;
        logic [31:0] ctl_exp;
        logic [31:0] exp_res;
        bit          long_op;
        long_op = !(op == 2'b11 || (op != 2'b00 && b == 0));
        ctl_exp = (op == 2'b00) ? 32'd0 : 32'd1;
        exp_res = ref_model(op, a, b);
        bif.start = 1'b1;
        bif.op    = op;
        bif.a     = a;
        bif.b     = b;
        @(negedge clk);
        bif.start = 1'b0;
        bif.a     = $urandom;
        bif.b     = $urandom;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            if (bif.done) begin
                lat = n;
                break;
            end
            check({tag, "_run_busy"}, 32'(bif.busy),        32'd1);
            check({tag, "_run_own"},  32'(bif.alu_own),     32'd1);
            check({tag, "_run_ctl"},  32'(bif.alu_control), ctl_exp);
            @(negedge clk);
        end
        check({tag, "_latency"}, 32'(lat), long_op ? 32'd33 : 32'd1);
        check({tag, "_result"},  bif.result, exp_res);
        check_quiet({tag, "_done"});
        last_result = exp_res;
    endtask

    task automatic step_idle(input string tag);
        @(negedge clk);
        check({tag, "_idle_done"}, 32'(bif.done), 32'd0);
        check({tag, "_idle_res"},  bif.result,    last_result);
        check_quiet({tag, "_idle"});
    endtask

    initial begin
        bif.start = 1'b0;
        bif.op    = 2'b00;
        bif.a     = '0;
        bif.b     = '0;
        bif.flush = 1'b0;
        reset     = 1'b1;
        last_result = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_done",   32'(bif.done), 32'd0);
        check("rst_result", bif.result,    32'd0);
        check_quiet("rst");
        reset = 1'b0;
        @(negedge clk);

        // Directed operations
        do_op(2'b00, 32'd7, 32'd6, "mul_7x6");
        check("mul_7x6_const", bif.result, 32'h0000_002A);
        step_idle("mul_7x6");
        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_ones");
        check("mul_ones_const", bif.result, 32'h0000_0001);
        do_op(2'b00, 32'd3, 32'd5, "mul_b2b");
        check("mul_b2b_const", bif.result, 32'h0000_000F);
        step_idle("mul_b2b");
        do_op(2'b01, 32'd100, 32'd7, "divu_100_7");
        step_idle("divu_100_7");
        do_op(2'b10, 32'd100, 32'd7, "remu_100_7");
        step_idle("remu_100_7");
        do_op(2'b01, 32'hFFFF_FFFF, 32'h8000_0001, "divu_carry");
        check("divu_carry_const", bif.result, 32'h0000_0001);
        step_idle("divu_carry");
        do_op(2'b10, 32'hFFFF_FFFF, 32'h8000_0001, "remu_carry");
        check("remu_carry_const", bif.result, 32'h7FFF_FFFE);
        step_idle("remu_carry");
        do_op(2'b01, 32'd5, 32'd0, "divu_by0");
        step_idle("divu_by0");
        do_op(2'b10, 32'd5, 32'd0, "remu_by0");
        step_idle("remu_by0");

        // Flush mid-MUL, with an ignored start while busy
        bif.start = 1'b1;
        bif.op    = 2'b00;
        bif.a     = 32'd123;
        bif.b     = 32'd456;
        @(negedge clk);
        bif.start = 1'b0;
        for (int i = 1; i < 10; i++) begin
            check("flush_run_busy", 32'(bif.busy), 32'd1);
            check("flush_run_done", 32'(bif.done), 32'd0);
            bif.start = (i == 4);
            bif.op    = 2'b11;
            @(negedge clk);
        end
        bif.flush = 1'b1;
        @(negedge clk);
        bif.flush = 1'b0;
        check("flush_after_done", 32'(bif.done), 32'd0);
        check("flush_after_res",  bif.result,    last_result);
        check_quiet("flush_after");
        repeat (26) step_idle("flush_wait");

        // flush beats start in IDLE
        bif.start = 1'b1;
        bif.op    = 2'b11;
        bif.flush = 1'b1;
        @(negedge clk);
        bif.start = 1'b0;
        bif.flush = 1'b0;
        check("flush_start_idle_busy", 32'(bif.busy), 32'd0);
        step_idle("flush_start_idle");

        // Reset mid-DIVU
        bif.start = 1'b1;
        bif.op    = 2'b01;
        bif.a     = 32'hDEAD_BEEF;
        bif.b     = 32'd7;
        @(negedge clk);
        bif.start = 1'b0;
        repeat (20) @(negedge clk);
        check("pre_rst_busy", 32'(bif.busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        last_result = 32'h0;
        check("midrst_done",   32'(bif.done), 32'd0);
        check("midrst_result", bif.result,    32'd0);
        check_quiet("midrst");
        do_op(2'b11, 32'h1234_5678, 32'h9ABC_DEF0, "rsvd_after_rst");
        step_idle("rsvd_after_rst");

        // Random operations, some back-to-back
        for (int k = 0; k < 24; k++) begin
            logic [1:0]  rop;
            logic [31:0] ra;
            logic [31:0] rb;
            int          sel;
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            sel = $urandom_range(0, 5);
            rb  = (sel == 0) ? 32'd0 : (sel < 3) ? 32'($urandom_range(1, 300)) : $urandom;
            do_op(rop, ra, rb, "rand");
            if ($urandom_range(0, 1) == 0) step_idle("rand");
        end
        step_idle("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
